load_mdu_stall_ctrl: RTL and testbench

Pipeline stall/flush sequencer for the 16-bit five-stage core. It sits between the ID stage and the PC / IF/ID / ID/EX pipeline registers. It arbitrates three stall/flush sources: load-use hazards, the multi-cycle multiply/divide unit (MDU) in EX, and taken branches resolved in EX. It drives the PC write enable, the IF/ID write enable, the IF/ID flush and the ID/EX bubble.

---
 rtl/hazard_pkg.sv | 24 ++
 rtl/load_mdu_stall_ctrl_if.sv | 39 +++
 rtl/load_mdu_stall_ctrl_detect.sv | 27 ++
 rtl/load_mdu_stall_ctrl.sv | 142 ++++++++++++++
 tb/tb_load_mdu_stall_ctrl.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg - shared definitions for load_mdu_stall_ctrl.
//   state_t    : sequencer states (ST_RUN, ST_LOAD_STALL, ST_MDU_WAIT)
//   *_HI/*_LO  : bit positions of the IF/ID instruction fields
//   NOP_INSTR  : encoding of the pipeline NOP
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MDU_WAIT   = 2'd2
    } state_t;

    localparam int OPC_HI  = 15;
    localparam int OPC_LO  = 12;
    localparam int SRC1_HI = 11;
    localparam int SRC1_LO = 8;
    localparam int SRC2_HI = 7;
    localparam int SRC2_LO = 4;
    localparam int DEST_HI = 3;
    localparam int DEST_LO = 0;

    localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/load_mdu_stall_ctrl_if.sv
// load_mdu_stall_ctrl_if - hazard inputs from ID/EX and the pipeline
// control outputs of the stall sequencer.
//   master : pipeline side, drives hazard inputs, receives controls
//   slave  : the stall sequencer
// stall_count is present only when HAZ_STALL_COUNT_EN is defined.
interface load_mdu_stall_ctrl_if;

    logic [15:0] ifid_instr;
    logic        idex_mread;
    logic [3:0]  idex_dest;
    logic        branch_taken;
    logic        mdu_start;
    logic        mdu_done;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        stall_active;
`ifdef HAZ_STALL_COUNT_EN
    logic [15:0] stall_count;
`endif

    modport master (
        output ifid_instr, idex_mread, idex_dest, branch_taken, mdu_start, mdu_done,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, stall_active
`ifdef HAZ_STALL_COUNT_EN
        , input stall_count
`endif
    );

    modport slave (
        input  ifid_instr, idex_mread, idex_dest, branch_taken, mdu_start, mdu_done,
        output pc_write, ifid_write, ifid_flush, idex_bubble, stall_active
`ifdef HAZ_STALL_COUNT_EN
        , output stall_count
`endif
    );

endinterface

// File: rtl/load_mdu_stall_ctrl_detect.sv
// load_use_detect - combinational load-use hazard detection.
//   ifid_instr : instruction in IF/ID (only src1/src2 are inspected)
//   idex_mread : instruction in ID/EX is a load
//   idex_dest  : destination of the ID/EX instruction
//   hz         : the IF/ID instruction reads the register being loaded
module load_use_detect
    import hazard_pkg::*;
(
    input  logic [15:0] ifid_instr,
    input  logic        idex_mread,
    input  logic [3:0]  idex_dest,
    output logic        hz
);

    logic [3:0] src1;
    logic [3:0] src2;
    logic       unused_fields;

    assign src1 = ifid_instr[SRC1_HI:SRC1_LO];
    assign src2 = ifid_instr[SRC2_HI:SRC2_LO];

    // Opcode and dest are deliberately not part of the hazard check.
    assign unused_fields = ^{ifid_instr[OPC_HI:OPC_LO], ifid_instr[DEST_HI:DEST_LO]};

    assign hz = idex_mread && ((idex_dest == src1) || (idex_dest == src2));

endmodule

// File: rtl/load_mdu_stall_ctrl.sv
// load_mdu_stall_ctrl - stall/flush sequencer between ID and the
// PC / IF/ID / ID/EX pipeline registers. Arbitrates MDU start, taken
// branch and load-use hazard (in that priority) with Mealy outputs.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : load_mdu_stall_ctrl_if.slave (hazard inputs, controls)
//   LOAD_LAT : total stall cycles per load-use hazard (1..15)
// Optional: HAZ_STALL_COUNT_EN adds a saturating stall-cycle counter.
//
// state         | meaning
// --------------+---------------------------------------------------
// ST_RUN        | pipeline flowing; new stall/flush sources accepted
// ST_LOAD_STALL | remaining cycles of a multi-cycle load-use stall
// ST_MDU_WAIT   | waiting for mdu_done; released in the done cycle
module load_mdu_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int LOAD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    load_mdu_stall_ctrl_if.slave  bus
);

    localparam logic [3:0] LOAD_RELOAD = 4'(LOAD_LAT - 1);
    localparam bit         LOAD_MULTI  = (LOAD_LAT > 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       hz;

    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;

    load_use_detect u_detect (
        .ifid_instr (bus.ifid_instr),
        .idex_mread (bus.idex_mread),
        .idex_dest  (bus.idex_dest),
        .hz         (hz)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;

        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_d     = ST_RUN;
            cnt_d       = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (bus.mdu_start) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        state_d     = ST_MDU_WAIT;
                    end else if (bus.branch_taken) begin
                        // Any hazard here belongs to a squashed instruction.
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (hz) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        cnt_d       = LOAD_RELOAD;
                        state_d     = LOAD_MULTI ? ST_LOAD_STALL : ST_RUN;
                    end
                end
                ST_LOAD_STALL: begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    cnt_d       = cnt_q - 4'd1;
                    // <= 1 rather than == 1 so a stray zero cannot lock up.
                    if (cnt_q <= 4'd1) begin
                        state_d = ST_RUN;
                    end
                end
                ST_MDU_WAIT: begin
                    if (bus.mdu_done) begin
                        state_d = ST_RUN;
                    end else begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign bus.pc_write     = pc_write;
    assign bus.ifid_write   = ifid_write;
    assign bus.ifid_flush   = ifid_flush;
    assign bus.idex_bubble  = idex_bubble;
    assign bus.stall_active = !pc_write && !rst;

`ifdef HAZ_STALL_COUNT_EN
    logic [15:0] stall_count_q, stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        if (bus.stall_active && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign bus.stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_load_mdu_stall_ctrl.sv
// Bench for load_mdu_stall_ctrl: two instances (LOAD_LAT 1 and 3) share
// the same stimulus and are compared every cycle against a behavioural
// model that tracks "extra load-stall cycles left" and "MDU busy".
module tb_load_mdu_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr;
    logic        mread;
    logic [3:0]  dest;
    logic        branch;
    logic        start;
    logic        done;

    int checks = 0;
    int errors = 0;

    int lat       [2] = '{1, 3};
    int load_left [2];
    bit busy      [2];
    int scnt      [2];

    always #5 clk = ~clk;

    load_mdu_stall_ctrl_if bus1 ();
    load_mdu_stall_ctrl_if bus3 ();

    assign bus1.ifid_instr   = instr;
    assign bus1.idex_mread   = mread;
    assign bus1.idex_dest    = dest;
    assign bus1.branch_taken = branch;
    assign bus1.mdu_start    = start;
    assign bus1.mdu_done     = done;
    assign bus3.ifid_instr   = instr;
    assign bus3.idex_mread   = mread;
    assign bus3.idex_dest    = dest;
    assign bus3.branch_taken = branch;
    assign bus3.mdu_start    = start;
    assign bus3.mdu_done     = done;

    load_mdu_stall_ctrl #(.LOAD_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    load_mdu_stall_ctrl #(.LOAD_LAT(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Inputs are set by the caller just after a rising edge; outputs are
    // checked on the falling edge and the model advances on the next rise.
    task automatic cycle();
        logic [3:0] e;
        logic [3:0] o;
        logic       sa;
        logic       osa;
        bit         hzm;
        int         nl  [2];
        bit         nb  [2];
        int         nc  [2];
        @(negedge clk);
        hzm = mread && ((dest == instr[11:8]) || (dest == instr[7:4]));
        for (int i = 0; i < 2; i++) begin
            nl[i] = load_left[i];
            nb[i] = busy[i];
            if (rst) begin
                e = 4'b0011; nl[i] = 0; nb[i] = 0;
            end else if (busy[i]) begin
                if (done) begin e = 4'b1100; nb[i] = 0; end
                else e = 4'b0001;
            end else if (load_left[i] > 0) begin
                e = 4'b0001; nl[i] = load_left[i] - 1;
            end else if (start) begin
                e = 4'b0001; nb[i] = 1;
            end else if (branch) begin
                e = 4'b1111;
            end else if (hzm) begin
                e = 4'b0001; nl[i] = lat[i] - 1;
            end else begin
                e = 4'b1100;
            end
            sa = !rst && !e[3];
            if (i == 0) begin
                o   = {bus1.pc_write, bus1.ifid_write, bus1.ifid_flush, bus1.idex_bubble};
                osa = bus1.stall_active;
            end else begin
                o   = {bus3.pc_write, bus3.ifid_write, bus3.ifid_flush, bus3.idex_bubble};
                osa = bus3.stall_active;
            end
            chk($sformatf("ctl{pc,ifw,flush,bub} L%0d", lat[i]), 32'(o), 32'(e));
            chk($sformatf("stall_active L%0d", lat[i]), 32'(osa), 32'(sa));
`ifdef HAZ_STALL_COUNT_EN
            chk($sformatf("stall_count L%0d", lat[i]),
                32'(i == 0 ? bus1.stall_count : bus3.stall_count),
                32'(rst ? 0 : scnt[i]));
`endif
            if (rst) nc[i] = 0;
            else if (sa && scnt[i] < 65535) nc[i] = scnt[i] + 1;
            else nc[i] = scnt[i];
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            load_left[i] = nl[i];
            busy[i]      = nb[i];
            scnt[i]      = nc[i];
        end
        #1;
    endtask

    task automatic idle();
        instr = 16'h0000; mread = 1'b0; dest = 4'h0;
        branch = 1'b0; start = 1'b0; done = 1'b0;
    endtask

    initial begin
        bit prev_start;
        for (int i = 0; i < 2; i++) begin
            load_left[i] = 0; busy[i] = 0; scnt[i] = 0;
        end
        idle();
        rst = 1'b1;
        #1;
        cycle(); cycle();
        rst = 1'b0;
        cycle(); cycle();

        // load-use: src2 matches
        instr = 16'h0246; mread = 1'b1; dest = 4'h4;
        cycle();
        idle(); cycle(); cycle(); cycle();
        // dest field match only: no hazard
        instr = 16'h0246; mread = 1'b1; dest = 4'h6;
        cycle();
        // not a load
        instr = 16'h0246; mread = 1'b0; dest = 4'h2;
        cycle();
        // inputs held through a multi-cycle load stall
        instr = 16'h0200; mread = 1'b1; dest = 4'h2;
        cycle(); cycle();
        idle(); cycle(); cycle(); cycle();

        // MDU: start then done five cycles later
        start = 1'b1; cycle();
        start = 1'b0; repeat (4) cycle();
        done = 1'b1; cycle();
        done = 1'b0; cycle();
        // stray done in RUN
        done = 1'b1; cycle();
        idle(); cycle();

        // branch beats hazard
        instr = 16'h0220; mread = 1'b1; dest = 4'h2; branch = 1'b1;
        cycle();
        idle(); cycle();
        // mdu_start beats branch
        start = 1'b1; branch = 1'b1; cycle();
        start = 1'b0; branch = 1'b1; cycle();
        branch = 1'b0; done = 1'b1; cycle();
        idle(); cycle();

        // reset mid-MDU
        start = 1'b1; cycle();
        start = 1'b0; cycle(); cycle();
        rst = 1'b1; cycle();
        rst = 1'b0; done = 1'b1; cycle();
        idle(); cycle(); cycle();

        // reset mid load stall (LOAD_LAT 3 instance)
        instr = 16'h0330; mread = 1'b1; dest = 4'h3; cycle();
        idle(); rst = 1'b1; cycle();
        rst = 1'b0; cycle(); cycle();

        prev_start = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            rst    = ($urandom_range(0, 59) == 0);
            instr  = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
                      4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
            mread  = 1'($urandom_range(0, 1));
            dest   = 4'($urandom_range(0, 3));
            branch = ($urandom_range(0, 5) == 0);
            start  = !prev_start && ($urandom_range(0, 7) == 0);
            done   = ($urandom_range(0, 3) == 0);
            prev_start = start;
            cycle();
        end

        idle();
        cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
